// File: rtl/dec_func_seq.sv
`default_nettype none
// ============================================================================
// Module      : dec_func_seq
// Description : Registered N-to-2^N one-hot decoder with N_FUNC programmable
//               sum-of-minterm function outputs and a built-in sweep engine
//               that walks every select code with a programmable dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_func_seq #(
  parameter int N_SEL       = 3,
  parameter int N_FUNC      = 3,
  parameter int SWEEP_DWELL = 4,
  localparam int NLINES     = 1 << N_SEL,
  localparam int IDX_W      = (N_FUNC > 1) ? $clog2(N_FUNC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              sel_valid_i,
  input  logic [N_SEL-1:0]  sel_i,
  input  logic              cfg_we_i,
  input  logic [IDX_W-1:0]  cfg_idx_i,
  input  logic [NLINES-1:0] cfg_mask_i,
  input  logic              sweep_start_i,
  output logic              busy_o,
  output logic [NLINES-1:0] dec_out_o,
  output logic              dec_valid_o,
  output logic [N_FUNC-1:0] f_out_o,
  output logic              sweep_done_o
);

  localparam int DW_W = (SWEEP_DWELL > 1) ? $clog2(SWEEP_DWELL) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q;
  logic [NLINES-1:0]   mask_q [N_FUNC];
  logic [N_SEL:0]      code_q;       // one extra bit so the terminal compare cannot wrap
  logic [DW_W-1:0]     dwell_q;
  logic [NLINES-1:0]   dec_out_q;
  logic [N_FUNC-1:0]   f_out_q;
  logic                dec_valid_q;
  logic                busy_q;
  logic                sweep_done_q;

  logic [N_SEL:0]      code_inc_d;
  logic [N_SEL-1:0]    cap_code_d;
  logic [NLINES-1:0]   cap_oh_d;
  logic [N_FUNC-1:0]   cap_f_d;
  logic                dwell_last_d;
  logic                code_last_d;
  logic                cfg_hit_d;

  assign code_inc_d   = code_q + (N_SEL+1)'(1);
  assign dwell_last_d = (dwell_q == DW_W'(SWEEP_DWELL - 1));
  assign code_last_d  = (code_q == (N_SEL+1)'(NLINES - 1));
  assign cfg_hit_d    = cfg_we_i && ({1'b0, cfg_idx_i} < (IDX_W+1)'(N_FUNC));

  // Select the code that would be captured at this edge: sweep start loads
  // code 0, a sweep step loads the next code, otherwise the external select.
  always_comb begin
    cap_code_d = sel_i;
    if (state_q == ST_IDLE && sweep_start_i) begin
      cap_code_d = '0;
    end else if (state_q == ST_SWEEP) begin
      cap_code_d = code_inc_d[N_SEL-1:0];
    end
  end

  assign cap_oh_d = NLINES'(1) << cap_code_d;

  // Each function is the OR of the decoded minterms its mask selects; masks
  // are the pre-edge values so a same-cycle write only affects later captures.
  always_comb begin
    cap_f_d = '0;
    for (int i = 0; i < N_FUNC; i++) begin
      cap_f_d[i] = |(mask_q[i] & cap_oh_d);
    end
  end

  // Mask registers, sweep FSM and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < N_FUNC; i++) begin
        mask_q[i] <= '0;
      end
      code_q       <= '0;
      dwell_q      <= '0;
      dec_out_q    <= '0;
      f_out_q      <= '0;
      dec_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else if (en_i) begin
      if (cfg_hit_d) begin
        mask_q[cfg_idx_i] <= cfg_mask_i;
      end
      case (state_q)
        ST_IDLE: begin
          sweep_done_q <= 1'b0;
          if (sweep_start_i) begin
            state_q     <= ST_SWEEP;
            code_q      <= '0;
            dwell_q     <= '0;
            dec_out_q   <= cap_oh_d;
            f_out_q     <= cap_f_d;
            dec_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end else if (sel_valid_i) begin
            dec_out_q   <= cap_oh_d;
            f_out_q     <= cap_f_d;
            dec_valid_q <= 1'b1;
          end else begin
            dec_valid_q <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (dwell_last_d) begin
            dwell_q <= '0;
            if (code_last_d) begin
              // Last dwell of the final code: outputs keep the final code.
              state_q      <= ST_DONE;
              dec_valid_q  <= 1'b0;
              sweep_done_q <= 1'b1;
            end else begin
              code_q      <= code_inc_d;
              dec_out_q   <= cap_oh_d;
              f_out_q     <= cap_f_d;
              dec_valid_q <= 1'b1;
            end
          end else begin
            dwell_q <= dwell_q + DW_W'(1);
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          sweep_done_q <= 1'b0;
          busy_q       <= 1'b0;
          dec_valid_q  <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          sweep_done_q <= 1'b0;
          dec_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign dec_out_o    = dec_out_q;
  assign dec_valid_o  = dec_valid_q;
  assign f_out_o      = f_out_q;
  assign sweep_done_o = sweep_done_q;

endmodule
`default_nettype wire

// File: doc/dec_func_seq.md
Name: dec_func_seq

Overview:
- Registered, parametrised N-to-2^N one-hot decoder with N_FUNC programmable sum-of-minterm function outputs.
- Each function is the OR of the decoded minterms selected by a runtime-loadable mask, replacing hard-wired function gates.
- A built-in sweep engine steps the select code through every input combination, with a programmable dwell per code, for self-exercise and bring-up.
- Sits between select-code producers and downstream enable/strobe logic.

Parameters:
N_SEL, 3, select width; decoder produces 2^N_SEL lines (legal range 1..6).
N_FUNC, 3, number of programmable function outputs (legal range 1..8).
SWEEP_DWELL, 4, cycles each code is held during a sweep (legal range >=1).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset.
en  in  1  clock enable; when 0 all state and outputs hold.
sel_valid  in  1  sel is valid this cycle (normal mode only).
sel  in  N_SEL  select code.
cfg_we  in  1  write cfg_mask into mask register cfg_idx.
cfg_idx  in  max(1,$clog2(N_FUNC))  function index to write.
cfg_mask  in  2^N_SEL  minterm mask; bit k set means minterm k is in the function.
sweep_start  in  1  request a full sweep.
busy  out  1  sweep in progress (states SWEEP or DONE).
dec_out  out  2^N_SEL  registered one-hot decode.
dec_valid  out  1  dec_out and f_out are valid this cycle.
f_out  out  N_FUNC  registered function outputs.
sweep_done  out  1  single-cycle pulse at end of sweep.

Behaviour:
- Reset (async, any time, including mid-sweep): state=IDLE, all masks=0, dec_out=0, f_out=0, dec_valid=0, busy=0, sweep_done=0, sweep code/dwell counters=0.
- en=0: no register changes. Masks, FSM, counters and outputs all hold, and cfg_we is ignored.
- Function rule: f_out[i] = OR over k of (mask[i][k] & onehot[k]). It is registered in the same edge as dec_out and uses mask values as they stood before that edge.
- Mask write: on an en edge with cfg_we=1 and cfg_idx<N_FUNC, mask[cfg_idx]<=cfg_mask. cfg_idx>=N_FUNC is ignored.
  - The write is allowed in any state and affects outputs from the next capture onward.
  - Outputs already registered are not recomputed.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - On an en edge with sel_valid=1: dec_out<=onehot(sel), f_out per the rule above, dec_valid<=1.
  - Latency is 1 cycle; back-to-back codes are accepted every cycle.
  - With sel_valid=0: dec_valid<=0, and dec_out/f_out hold their last values.
- IDLE with sweep_start=1 (en=1):
  - Next state is SWEEP; sweep_start has priority over sel_valid in the same cycle.
  - Code=0 and dwell=0 are loaded.
  - dec_out<=onehot(0), dec_valid<=1, busy<=1.
- SWEEP:
  - Each en edge increments dwell.
  - When dwell reaches SWEEP_DWELL-1: dwell<=0, code<=code+1, and outputs are loaded from the new code.
  - Each code is therefore presented for exactly SWEEP_DWELL valid cycles.
  - When the last dwell cycle of code 2^N_SEL-1 ends, next state is DONE and dec_valid<=0.
  - sel_valid and sweep_start are ignored throughout.
  - The code counter is N_SEL+1 bits wide so the terminal compare does not wrap.
- DONE: one cycle with sweep_done=1, busy=1, dec_valid=0, and dec_out/f_out holding code 2^N_SEL-1. Next state is IDLE.
- Total sweep: busy high for 2^N_SEL*SWEEP_DWELL+1 en cycles.
- sweep_start held high in DONE is ignored. It starts a new sweep only if still high in IDLE.
- dec_out is always either zero (reset) or exactly one-hot.

Test Plan:
- Reset and basic decode: assert rst mid-operation -> all outputs 0 at once without waiting for a clock. Then with masks 0 and sel=0..7 on consecutive cycles (N_SEL=3) -> dec_out 0x01,0x02,...,0x80 one cycle later, dec_valid=1 each cycle, f_out=0.
- Function masks: load mask0=0x96 (odd parity), mask1=0xE8 (majority), mask2=0x01, then sel=3 -> f_out=3'b010; sel=7 -> f_out=3'b011; sel=0 -> f_out=3'b100; sel=4 -> f_out=3'b001.
- Write/capture ordering: cfg_we to mask0=0xFF in the same cycle as sel_valid with sel=1 -> that capture uses the old mask; the next capture of sel=1 -> f_out[0]=1. cfg_idx=3 write -> no mask changes.
- Sweep: N_SEL=3, SWEEP_DWELL=4, pulse sweep_start -> dec_out 0x01 for 4 cycles, then 0x02 for 4 cycles, through 0x80, with dec_valid high 32 cycles. sweep_done pulses once on cycle 33, and busy is high for 33 cycles. sel_valid traffic during the sweep has no effect.
- en gating: drop en for 5 cycles mid-sweep -> outputs and counters frozen, and the sweep still totals 32 valid en-cycles.
- Reset mid-sweep: rst during code 5 -> IDLE immediately, busy=0, masks cleared, and no sweep_done pulse.
